// File: rtl/pipeline_ctrl_pkg.sv
// pipeline_ctrl_pkg
//   Shared constants for the pipeline control block: default geometry of the
//   pipeline (stage count, inter-stage bus width, counter width) and the
//   canonical stage indices of the five-stage CPU.
package pipeline_ctrl_pkg;

  localparam int unsigned NSTAGE_DEF = 5;
  localparam int unsigned BUS_W_DEF  = 64;
  localparam int unsigned CNT_W_DEF  = 32;

  localparam int unsigned STG_IF  = 0;
  localparam int unsigned STG_ID  = 1;
  localparam int unsigned STG_EX  = 2;
  localparam int unsigned STG_MEM = 3;
  localparam int unsigned STG_WB  = 4;

endpackage

// File: rtl/pipeline_ctrl_n_if.sv
// pipeline_ctrl_n_if
//   Bundle between the stage modules (master) and the pipeline controller
//   (slave).
//   master -> slave : stage_over, stage_bus, flush_req, freeze, clr_cnt
//   slave -> master : valid, allow_in, bus_r, next_fetch, flush_any,
//                     retire_cnt, stall_cnt
interface pipeline_ctrl_n_if
  import pipeline_ctrl_pkg::*;
#(
  parameter int unsigned NSTAGE = NSTAGE_DEF,
  parameter int unsigned BUS_W  = BUS_W_DEF,
  parameter int unsigned CNT_W  = CNT_W_DEF
);

  logic [NSTAGE-1:0]           stage_over;
  logic [(NSTAGE-1)*BUS_W-1:0] stage_bus;
  logic [NSTAGE-1:0]           flush_req;
  logic                        freeze;
  logic                        clr_cnt;
  logic [NSTAGE-1:0]           valid;
  logic [NSTAGE-1:0]           allow_in;
  logic [(NSTAGE-1)*BUS_W-1:0] bus_r;
  logic                        next_fetch;
  logic                        flush_any;
  logic [CNT_W-1:0]            retire_cnt;
  logic [CNT_W-1:0]            stall_cnt;

  modport master (
    output stage_over, stage_bus, flush_req, freeze, clr_cnt,
    input  valid, allow_in, bus_r, next_fetch, flush_any, retire_cnt, stall_cnt
  );

  modport slave (
    input  stage_over, stage_bus, flush_req, freeze, clr_cnt,
    output valid, allow_in, bus_r, next_fetch, flush_any, retire_cnt, stall_cnt
  );

endinterface

// File: rtl/pipeline_ctrl_n_stage_reg.sv
// pipe_stage_reg
//   One inter-stage register: the valid bit of a stage plus the bus it
//   received from the stage before it.
//   clk, resetn : clock, asynchronous active-low reset
//   i_load      : capture i_bus and mark the stage valid
//   i_kill      : mark the stage empty (bus contents kept); wins over i_load
//   i_bus       : incoming bus from the previous stage
//   o_valid     : stage holds an instruction
//   o_bus       : registered bus feeding this stage
//   Neither load nor kill: hold.
module pipe_stage_reg
  import pipeline_ctrl_pkg::*;
#(
  parameter int unsigned BUS_W = BUS_W_DEF
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             i_load,
  input  logic             i_kill,
  input  logic [BUS_W-1:0] i_bus,
  output logic             o_valid,
  output logic [BUS_W-1:0] o_bus
);

  logic             r_valid;
  logic [BUS_W-1:0] r_bus;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_valid <= 1'b0;
      r_bus   <= '0;
    end else if (i_kill) begin
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_bus   <= i_bus;
    end
  end

  assign o_valid = r_valid;
  assign o_bus   = r_bus;

endmodule

// File: rtl/pipeline_ctrl_n.sv
// pipeline_ctrl_n
//   Pipeline control and inter-stage registers for an NSTAGE-deep CPU.
//   Produces per-stage valid / allow_in, holds the stage-to-stage buses,
//   handles partial flushes requested by any stage and a global freeze, and
//   keeps retire / fetch-stall counters.
//   clk, resetn : clock, asynchronous active-low reset
//   pc (slave)  : stage_over, stage_bus, flush_req, freeze, clr_cnt in;
//                 valid, allow_in, bus_r, next_fetch, flush_any,
//                 retire_cnt, stall_cnt out
module pipeline_ctrl_n
  import pipeline_ctrl_pkg::*;
#(
  parameter int unsigned NSTAGE = NSTAGE_DEF,
  parameter int unsigned BUS_W  = BUS_W_DEF,
  parameter int unsigned CNT_W  = CNT_W_DEF
) (
  input  logic                clk,
  input  logic                resetn,
  pipeline_ctrl_n_if.slave    pc
);

  logic                        r_valid0;
  logic [NSTAGE-1:1]           w_valid_hi;
  logic [NSTAGE-1:0]           w_valid;
  logic [NSTAGE-1:0]           w_over_q;
  logic [NSTAGE-1:0]           w_kill_src;
  logic [NSTAGE-1:0]           w_allow;
  logic [NSTAGE-1:1]           w_load;
  logic [NSTAGE-1:1]           w_kill;
  logic                        w_flush_any;
  logic [(NSTAGE-1)*BUS_W-1:0] w_bus_r;
  logic [CNT_W-1:0]            r_retire;
  logic [CNT_W-1:0]            r_stall;

  assign w_valid = {w_valid_hi, r_valid0};

  // w_kill_src[j] marks stage j's instruction as cancelled this cycle. A flush
  // from stage k cancels stages 1..k, so this is a suffix-OR of flush_req
  // rather than an explicit highest-bit index. Fetch (stage 0) shares the
  // fate of stage 1: its output is wrong-path whenever any flush is active.
  always_comb begin
    logic [NSTAGE-1:0] kill_acc;
    w_over_q = w_valid & pc.stage_over;
    kill_acc = '0;
    kill_acc[NSTAGE-1] = pc.flush_req[NSTAGE-1];
    for (int unsigned i = NSTAGE - 2; i >= 1; i--) begin
      kill_acc[i] = pc.flush_req[i] | kill_acc[i+1];
    end
    kill_acc[0] = kill_acc[1];
    w_kill_src  = kill_acc;
  end

  assign w_flush_any = w_kill_src[1];

  // Back-pressure chain from the last stage toward fetch. A flush always
  // lets fetch advance (redirect) and overrides a freeze.
  always_comb begin
    logic [NSTAGE-1:0] allow_acc;
    allow_acc = '0;
    allow_acc[NSTAGE-1] = ~w_valid[NSTAGE-1] | w_over_q[NSTAGE-1];
    for (int unsigned i = NSTAGE - 2; i >= 1; i--) begin
      allow_acc[i] = ~w_valid[i] | (w_over_q[i] & allow_acc[i+1]);
    end
    allow_acc[0] = (w_over_q[0] & allow_acc[1]) | w_flush_any;
    w_allow = (pc.freeze & ~w_flush_any) ? '0 : allow_acc;
  end

  // Stage i loads from stage i-1 only if that instruction survives the
  // flush; an accepting stage with nothing to load becomes a bubble.
  always_comb begin
    w_load = '0;
    w_kill = '0;
    for (int unsigned i = 1; i < NSTAGE; i++) begin
      w_load[i] = w_over_q[i-1] & w_allow[i] & ~w_kill_src[i-1];
      w_kill[i] = w_kill_src[i] | (w_allow[i] & ~w_load[i]);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_valid0 <= 1'b0;
    end else begin
      r_valid0 <= 1'b1;
    end
  end

  for (genvar g = 1; g < NSTAGE; g++) begin : g_stage
    pipe_stage_reg #(
      .BUS_W (BUS_W)
    ) u_stage_reg (
      .clk     (clk),
      .resetn  (resetn),
      .i_load  (w_load[g]),
      .i_kill  (w_kill[g]),
      .i_bus   (pc.stage_bus[(g-1)*BUS_W +: BUS_W]),
      .o_valid (w_valid_hi[g]),
      .o_bus   (w_bus_r[(g-1)*BUS_W +: BUS_W])
    );
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_retire <= '0;
      r_stall  <= '0;
    end else if (pc.clr_cnt) begin
      r_retire <= '0;
      r_stall  <= '0;
    end else begin
      if (w_over_q[NSTAGE-1] & ~pc.freeze) begin
        r_retire <= r_retire + CNT_W'(1);
      end
      if (w_over_q[0] & ~w_allow[1] & ~w_flush_any & ~pc.freeze) begin
        r_stall <= r_stall + CNT_W'(1);
      end
    end
  end

  assign pc.valid      = w_valid;
  assign pc.allow_in   = w_allow;
  assign pc.bus_r      = w_bus_r;
  assign pc.next_fetch = w_allow[0];
  assign pc.flush_any  = w_flush_any;
  assign pc.retire_cnt = r_retire;
  assign pc.stall_cnt  = r_stall;

endmodule

// File: tb/tb_pipeline_ctrl_n.sv
module tb_pipeline_ctrl_n;

  localparam int unsigned NS = 5;
  localparam int unsigned BW = 16;
  localparam int unsigned CW = 4;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  pipeline_ctrl_n_if #(.NSTAGE(NS), .BUS_W(BW), .CNT_W(CW)) ifc ();

  pipeline_ctrl_n #(.NSTAGE(NS), .BUS_W(BW), .CNT_W(CW)) dut (
    .clk    (clk),
    .resetn (resetn),
    .pc     (ifc.slave)
  );

  int passed = 0;
  int total  = 0;

  // Reference model: occupancy per stage, held bus per stage boundary,
  // counters as plain integers.
  bit   [NS-1:0] mv;
  logic [BW-1:0] mb [NS-1];
  int unsigned   mret, mstall;
  bit   [NS-1:0] ma, moq;
  bit            mfany;
  int            mK;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  function automatic logic [63:0] mb_pack();
    logic [63:0] p;
    p = '0;
    for (int i = 0; i < NS - 1; i++) p[i*BW +: BW] = mb[i];
    return p;
  endfunction

  task automatic model_reset();
    mv = '0;
    for (int i = 0; i < NS - 1; i++) mb[i] = '0;
    mret = 0;
    mstall = 0;
  endtask

  task automatic model_comb(input logic [NS-1:0] over, input logic [NS-1:0] flush, input bit frz);
    mK = 0;
    for (int k = 1; k < NS; k++) if (flush[k]) mK = k;
    mfany = (mK != 0);
    for (int i = 0; i < NS; i++) moq[i] = mv[i] && over[i];
    ma[NS-1] = !mv[NS-1] || moq[NS-1];
    for (int i = NS - 2; i >= 1; i--) ma[i] = !mv[i] || (moq[i] && ma[i+1]);
    ma[0] = (moq[0] && ma[1]) || mfany;
    if (frz && !mfany) ma = '0;
  endtask

  task automatic cycle(input logic [NS-1:0] over, input logic [NS-1:0] flush,
                       input bit frz, input bit clr);
    logic [63:0]   rb;
    bit   [NS-1:0] nv;
    logic [BW-1:0] nb [NS-1];
    rb = {$urandom(), $urandom()};
    ifc.stage_over = over;
    ifc.stage_bus  = rb;
    ifc.flush_req  = flush;
    ifc.freeze     = frz;
    ifc.clr_cnt    = clr;
    #1;
    model_comb(over, flush, frz);
    chk("allow_in", 64'(ifc.allow_in), 64'(ma));
    chk("next_fetch", 64'(ifc.next_fetch), 64'(ma[0]));
    chk("flush_any", 64'(ifc.flush_any), 64'(mfany));
    nv[0] = 1'b1;
    nb = mb;
    for (int i = 1; i < NS; i++) begin
      if (mfany && i <= mK) nv[i] = 1'b0;
      else if (ma[i]) begin
        nv[i] = moq[i-1] && !(mfany && (i - 1) <= mK);
        if (nv[i]) nb[i-1] = rb[(i-1)*BW +: BW];
      end else nv[i] = mv[i];
    end
    if (clr) begin
      mret = 0;
      mstall = 0;
    end else begin
      if (moq[NS-1] && !frz) mret = (mret + 1) % (1 << CW);
      if (moq[0] && !ma[1] && !mfany && !frz) mstall = (mstall + 1) % (1 << CW);
    end
    @(posedge clk);
    #1;
    mv = nv;
    mb = nb;
    chk("valid", 64'(ifc.valid), 64'(mv));
    chk("bus_r", 64'(ifc.bus_r), mb_pack());
    chk("retire_cnt", 64'(ifc.retire_cnt), 64'(mret));
    chk("stall_cnt", 64'(ifc.stall_cnt), 64'(mstall));
  endtask

  task automatic run_flow(input int n);
    for (int i = 0; i < n; i++) cycle('1, '0, 1'b0, 1'b0);
  endtask

  initial begin
    int unsigned s0;
    logic [NS-1:0] ro, rf;
    ifc.stage_over = '0;
    ifc.stage_bus  = '0;
    ifc.flush_req  = '0;
    ifc.freeze     = 1'b0;
    ifc.clr_cnt    = 1'b0;
    model_reset();
    #1;
    chk("rst_valid", 64'(ifc.valid), 64'd0);
    chk("rst_bus_r", 64'(ifc.bus_r), 64'd0);
    chk("rst_retire", 64'(ifc.retire_cnt), 64'd0);
    chk("rst_stall", 64'(ifc.stall_cnt), 64'd0);
    chk("rst_allow_in", 64'(ifc.allow_in), 64'b11110);
    chk("rst_next_fetch", 64'(ifc.next_fetch), 64'd0);

    @(negedge clk);
    resetn = 1'b1;

    // Fill: valid grows one stage per edge.
    for (int i = 0; i < NS; i++) begin
      cycle('1, '0, 1'b0, 1'b0);
      chk("fill_valid", 64'(ifc.valid), 64'((1 << (i + 1)) - 1));
    end

    // Stage 3 stalls for three cycles.
    s0 = mstall;
    cycle(5'b10111, '0, 1'b0, 1'b0);
    chk("stall_valid", 64'(ifc.valid), 64'b01111);
    cycle(5'b10111, '0, 1'b0, 1'b0);
    cycle(5'b10111, '0, 1'b0, 1'b0);
    chk("stall_cnt_plus3", 64'(ifc.stall_cnt), 64'((s0 + 3) % 16));

    // Flush from writeback.
    run_flow(NS);
    cycle('1, 5'b10000, 1'b0, 1'b0);
    chk("flush4_valid", 64'(ifc.valid), 64'b00001);

    // Flush from stage 2 while 3/4 flow.
    run_flow(NS);
    cycle('1, 5'b00100, 1'b0, 1'b0);
    chk("flush2_valid", 64'(ifc.valid), 64'b10001);
    run_flow(1);

    // Freeze holds everything; flush overrides freeze.
    run_flow(NS);
    for (int i = 0; i < 4; i++) cycle('1, '0, 1'b1, 1'b0);
    chk("freeze_valid", 64'(ifc.valid), 64'b11111);
    cycle('1, 5'b10000, 1'b1, 1'b0);
    chk("freeze_flush_valid", 64'(ifc.valid), 64'b00001);

    // Retire counter wrap and clear priority.
    run_flow(NS);
    cycle('1, '0, 1'b0, 1'b1);
    chk("clr_retire", 64'(ifc.retire_cnt), 64'd0);
    run_flow(15);
    chk("retire_15", 64'(ifc.retire_cnt), 64'd15);
    run_flow(1);
    chk("retire_wrap", 64'(ifc.retire_cnt), 64'd0);
    run_flow(1);
    cycle('1, '0, 1'b0, 1'b1);
    chk("clr_over_retire", 64'(ifc.retire_cnt), 64'd0);

    // Random traffic against the model.
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < NS; i++) ro[i] = ($urandom_range(0, 3) != 0);
      rf = '0;
      if ($urandom_range(0, 9) == 0) rf[$urandom_range(1, NS - 1)] = 1'b1;
      cycle(ro, rf, ($urandom_range(0, 11) == 0), ($urandom_range(0, 29) == 0));
    end

    // Asynchronous reset in the middle of traffic.
    #2;
    resetn = 1'b0;
    #1;
    chk("async_rst_valid", 64'(ifc.valid), 64'd0);
    chk("async_rst_bus_r", 64'(ifc.bus_r), 64'd0);
    chk("async_rst_retire", 64'(ifc.retire_cnt), 64'd0);
    model_reset();
    @(negedge clk);
    resetn = 1'b1;
    for (int n = 0; n < 60; n++) begin
      for (int i = 0; i < NS; i++) ro[i] = ($urandom_range(0, 3) != 0);
      rf = '0;
      if ($urandom_range(0, 9) == 0) rf[$urandom_range(1, NS - 1)] = 1'b1;
      cycle(ro, rf, ($urandom_range(0, 11) == 0), 1'b0);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
